// File: rtl/ex_mdu_if.sv
// ex_mdu_if: execute-stage <-> multiply/divide unit bundle.
//   master (execute stage): drives start/kill/funct3/operands/rd, observes status and write-back.
//   slave (ex_mdu): the reverse.
interface ex_mdu_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) ();
  logic                  start_i;
  logic                  kill_i;
  logic [2:0]            funct3_i;
  logic [XLEN-1:0]       op1_i;
  logic [XLEN-1:0]       op2_i;
  logic [REG_ADDR_W-1:0] reg_waddr_i;
  logic                  busy_o;
  logic                  hold_flag_o;
  logic                  valid_o;
  logic                  reg_we_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]       reg_wdata_o;
  modport master (
    output start_i, kill_i, funct3_i, op1_i, op2_i, reg_waddr_i,
    input  busy_o, hold_flag_o, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );
  modport slave (
    input  start_i, kill_i, funct3_i, op1_i, op2_i, reg_waddr_i,
    output busy_o, hold_flag_o, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit retiring STEP_BITS bits per cycle.
//   clk, rst (async, active-low), bus (ex_mdu_if.slave): start/kill/funct3/op1/op2/rd in;
//   busy, hold_flag (combinational), valid/reg_we/reg_waddr/reg_wdata (registered) out.
module ex_mdu #(
  parameter int XLEN       = 32,
  parameter int STEP_BITS  = 1,
  parameter int REG_ADDR_W = 5
) (
  input logic    clk,
  input logic    rst,
  ex_mdu_if.slave bus
);
  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  neg_q, neg_d, valid_q, valid_d;
  logic [XLEN-1:0]       b_q, b_d, wdata_q, wdata_d;
  logic [2*XLEN-1:0]     p_q, p_d;
  logic                  s1, s2, n1, n2, dz, ovf, sp, accept;
  logic [XLEN-1:0]       m1, m2, sp_res, dsel, res;
  logic [XLEN:0]         acc;
  logic [2*XLEN-1:0]     pn, full;
  // Operand signedness: divides key on funct3[0], multiplies on funct3[1:0].
  assign s1     = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
  assign s2     = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
  assign n1     = s1 & bus.op1_i[XLEN-1];
  assign n2     = s2 & bus.op2_i[XLEN-1];
  assign m1     = n1 ? -bus.op1_i : bus.op1_i;
  assign m2     = n2 ? -bus.op2_i : bus.op2_i;
  assign dz     = bus.op2_i == '0;
  assign ovf    = ~bus.funct3_i[0] & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op2_i);
  assign sp     = bus.funct3_i[2] & (dz | ovf);
  assign sp_res = dz ? (bus.funct3_i[1] ? bus.op1_i : '1) : (bus.funct3_i[1] ? '0 : bus.op1_i);
  assign accept = (state_q == IDLE) & bus.start_i & ~bus.kill_i;
  // One CALC cycle: STEP_BITS rounds of shift-add (multiplier in low half) or
  // restoring divide (dividend shifting out of low half, remainder in high half).
  always_comb begin
    pn  = p_q;
    acc = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (!f3_q[2]) begin
        acc = {1'b0, pn[2*XLEN-1:XLEN]} + (pn[0] ? {1'b0, b_q} : '0);
        pn  = {acc, pn[XLEN-1:1]};
      end else begin
        acc = {pn[2*XLEN-1:XLEN], pn[XLEN-1]};
        pn  = (acc >= {1'b0, b_q}) ? {acc[XLEN-1:0] - b_q, pn[XLEN-2:0], 1'b1}
                                   : {acc[XLEN-1:0], pn[XLEN-2:0], 1'b0};
      end
    end
    full = neg_q ? -pn : pn;
    dsel = f3_q[1] ? pn[2*XLEN-1:XLEN] : pn[XLEN-1:0];
    res  = f3_q[2] ? (neg_q ? -dsel : dsel) : (|f3_q[1:0] ? full[2*XLEN-1:XLEN] : full[XLEN-1:0]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    b_d     = b_q;
    p_d     = p_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        f3_d    = bus.funct3_i;
        rd_d    = bus.reg_waddr_i;
        neg_d   = n1 ^ (n2 & ~(bus.funct3_i[2] & bus.funct3_i[1]));
        b_d     = bus.funct3_i[2] ? m2 : m1;
        p_d     = {{XLEN{1'b0}}, bus.funct3_i[2] ? m1 : m2};
        cnt_d   = CW'(N);
        state_d = sp ? DONE : CALC;
        wdata_d = sp ? sp_res : wdata_q;
        valid_d = sp;
      end
      CALC: begin
        p_d     = pn;
        cnt_d   = cnt_q - CW'(1);
        state_d = bus.kill_i ? IDLE : (cnt_q == CW'(1)) ? DONE : CALC;
        valid_d = ~bus.kill_i & (cnt_q == CW'(1));
        wdata_d = valid_d ? res : wdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      p_q     <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      p_q     <= p_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end
  assign bus.busy_o      = state_q != IDLE;
  assign bus.hold_flag_o = accept | (state_q == CALC);
  // A kill arriving in DONE must still suppress the write that cycle.
  assign bus.valid_o     = valid_q & ~bus.kill_i;
  assign bus.reg_we_o    = valid_q & ~bus.kill_i;
  assign bus.reg_waddr_o = rd_q;
  assign bus.reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: drives a STEP_BITS=1 and a STEP_BITS=4 ex_mdu in lockstep against an arithmetic model.
module tb_ex_mdu;
  logic        clk = 0, rst = 0, start = 0, kill = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic [4:0]  rd = 0;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  ex_mdu_if #(.XLEN(32), .REG_ADDR_W(5)) b1 ();
  ex_mdu_if #(.XLEN(32), .REG_ADDR_W(5)) b4 ();
  assign b1.start_i = start;  assign b4.start_i = start;
  assign b1.kill_i = kill;    assign b4.kill_i = kill;
  assign b1.funct3_i = f3;    assign b4.funct3_i = f3;
  assign b1.op1_i = op1;      assign b4.op1_i = op1;
  assign b1.op2_i = op2;      assign b4.op2_i = op2;
  assign b1.reg_waddr_i = rd; assign b4.reg_waddr_i = rd;
  ex_mdu #(.XLEN(32), .STEP_BITS(1), .REG_ADDR_W(5)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ex_mdu #(.XLEN(32), .STEP_BITS(4), .REG_ADDR_W(5)) d4 (.clk(clk), .rst(rst), .bus(b4.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(b); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : a;
        if (!f[0]) p = f[1] ? sa % sb : sa / sb;
        else p = {32'b0, f[1] ? a % b : a / b};
      end
    endcase
    return p[31:0];
  endfunction
  function automatic bit is_sp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction
  task automatic judge(input string tag, input int lat, input int kc, input int v, input int w, input int h,
                       input int l, input logic [31:0] d, input logic [4:0] ad, input logic bz,
                       input logic [31:0] e, input logic [4:0] r);
    if (kc < 0 || kc > lat) begin
      chk({tag, " valid_cnt"}, v, 1);
      chk({tag, " we_cnt"}, w, 1);
      chk({tag, " wdata"}, d, e);
      chk({tag, " waddr"}, {27'b0, ad}, {27'b0, r});
      chk({tag, " latency"}, l, lat);
      chk({tag, " hold_cycles"}, h, lat);
    end else begin
      chk({tag, " killed_valid_cnt"}, v, 0);
      chk({tag, " killed_we_cnt"}, w, 0);
      chk({tag, " killed_hold"}, h, kc == 0 ? 0 : (kc == lat ? lat : kc + 1));
      if (kc > 0) chk({tag, " killed_busy"}, {31'b0, bz}, 0);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int kc, input int ks);
    logic [31:0] e = model(f, a, b), d1v = 0, d4v = 0;
    logic [4:0] a1 = 0, a4 = 0;
    logic bz1 = 1, bz4 = 1;
    int v1 = 0, v4 = 0, w1 = 0, w4 = 0, h1 = 0, h4 = 0, l1 = -1, l4 = -1;
    bit sp = is_sp(f, a, b);
    @(negedge clk);
    start = 1; f3 = f; op1 = a; op2 = b; rd = r; kill = (kc == 0);
    for (int k = 0; k < 45; k++) begin
      #1;
      if (b1.hold_flag_o) h1++;
      if (b4.hold_flag_o) h4++;
      if (b1.reg_we_o) w1++;
      if (b4.reg_we_o) w4++;
      if (b1.valid_o) begin v1++; d1v = b1.reg_wdata_o; a1 = b1.reg_waddr_o; l1 = k; end
      if (b4.valid_o) begin v4++; d4v = b4.reg_wdata_o; a4 = b4.reg_waddr_o; l4 = k; end
      if (k == kc + 1) begin bz1 = b1.busy_o; bz4 = b4.busy_o; end
      @(negedge clk);
      if (k + 1 >= ks) start = 0;
      kill = (k + 1 == kc);
    end
    start = 0; kill = 0;
    judge({tag, "/s1"}, sp ? 1 : 33, kc, v1, w1, h1, l1, d1v, a1, bz1, e, r);
    judge({tag, "/s4"}, sp ? 1 : 9, kc, v4, w4, h4, l4, d4v, a4, bz4, e, r);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, b1.busy_o}, 0);
    chk("rst valid", {31'b0, b1.valid_o | b4.valid_o}, 0);
    chk("rst we", {31'b0, b1.reg_we_o | b4.reg_we_o}, 0);
    chk("rst waddr", {27'b0, b1.reg_waddr_o | b4.reg_waddr_o}, 0);
    chk("rst wdata", b1.reg_wdata_o | b4.reg_wdata_o, 0);
    rst = 1;
    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, -1, 1);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd4, -1, 1);
    run_op("mulhu_min", 3'd3, 32'h80000000, 32'h80000000, 5'd5, -1, 1);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd6, -1, 1);
    run_op("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, -1, 1);
    run_op("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, -1, 1);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, -1, 1);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, -1, 1);
    run_op("divu_z", 3'd5, 32'd100, 32'd0, 5'd11, -1, 1);
    run_op("remu_z", 3'd7, 32'd100, 32'd0, 5'd12, -1, 1);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, -1, 1);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, -1, 1);
    run_op("rd0", 3'd0, 32'd3, 32'd5, 5'd0, -1, 1);
    run_op("kill_calc10", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd15, 10, 1);
    run_op("kill_accept", 3'd0, 32'd7, 32'd9, 5'd16, 0, 1);
    run_op("kill_done_sp", 3'd5, 32'd100, 32'd0, 5'd17, 1, 1);
    run_op("mul_step4", 3'd0, 32'h12345678, 32'h10, 5'd18, -1, 8);
    @(negedge clk);
    start = 1; f3 = 3'd0; op1 = 32'd11; op2 = 32'd13; rd = 5'd19;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 0;
    #1;
    chk("midrst busy", {31'b0, b1.busy_o | b4.busy_o}, 0);
    chk("midrst hold", {31'b0, b1.hold_flag_o | b4.hold_flag_o}, 0);
    chk("midrst valid", {31'b0, b1.valid_o | b1.reg_we_o}, 0);
    chk("midrst waddr", {27'b0, b1.reg_waddr_o}, 0);
    chk("midrst wdata", b1.reg_wdata_o | b4.reg_wdata_o, 0);
    @(negedge clk);
    rst = 1;
    run_op("after_rst", 3'd0, 32'd11, 32'd13, 5'd20, -1, 1);
    for (int i = 0; i < 40; i++) begin
      int kc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 35)) : -1;
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), kc, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
